// File: rtl/spim1_port_slave.sv
// spim1_port_slave
//   SPI mode-0 target answering the HPS spim1 master. Each 16-bit frame is
//   {W, ADDR[6:0], DATA[7:0]}, MSB first. Registers: 0 LED (RW), 1 GPIO (RW),
//   2 KEY (RO), 3 ID (RO), 4 FCNT (RO). Every other address reads 0x00, and
//   writes to it are dropped.
//   All SPI pins are oversampled on clk_clk. SCLK must be at most clk_clk/8.
//
//   Optional feature: define SPIM1_PORT_SLAVE_FCNT_EN to build register 4 as
//   a count of completed frames. Without it, register 4 reads 0x00.
//
// Ports
//   clk_clk        fabric clock; the only clock domain
//   reset_reset_n  async-assert, active-low reset
//   spi_sclk       SPI clock (CPOL=0, CPHA=0)
//   spi_mosi       master-out data
//   spi_ss_n       active-low select
//   spi_miso       target-out data (0 when not returning read data)
//   ports_key[1:0] raw push buttons, asynchronous
//   ports_led[7:0] LED register
//   ports_gpio[7:0] GPIO register
module spim1_port_slave #(
  parameter logic [7:0] ID_VALUE    = 8'h5A,
  parameter int         SYNC_STAGES = 2     // synchronizer depth, >= 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  input  logic [1:0] ports_key,
  output logic [7:0] ports_led,
  output logic [7:0] ports_gpio
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  // Synchronizer lanes: {key[1:0], ss_n, mosi, sclk}.
  // The chain resets to all-zero, so SS_N starts out "selected". The FSM
  // therefore only enters CMD on an observed high->low transition of SS_N.
  // If the master is mid-frame when reset releases, the FSM parks in DONE
  // until SS_N goes high.
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] sync_s;
  logic       sclk_s, mosi_s, ss_s;
  logic [1:0] key_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sync_q <= '0;
    else                sync_q <= {sync_q[SYNC_STAGES-2:0],
                                   {ports_key, spi_ss_n, spi_mosi, spi_sclk}};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign sclk_s = sync_s[0];
  assign mosi_s = sync_s[1];
  assign ss_s   = sync_s[2];
  assign key_s  = sync_s[4:3];

  // The edge strobes are registered. MOSI is captured in the same cycle as
  // the rising strobe, so mosi_q is the bit that belongs to rise_q.
  logic sclk_d, ss_d, rise_q, fall_q, mosi_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_d <= 1'b0;
      ss_d   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
      rise_q <= sclk_s & ~sclk_d;
      fall_q <= ~sclk_s & sclk_d;
      mosi_q <= mosi_s;
    end
  end

  // ---------------- FSM ----------------
  state_t     st, nxt;
  logic [3:0] bit_cnt;
  logic       w_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) st <= IDLE;
    else                st <= nxt;
  end

  always_comb begin
    nxt = st;
    if (ss_s) nxt = IDLE;
    else begin
      case (st)
        IDLE: nxt = ss_d ? CMD : DONE;   // no observed falling SS_N -> stale frame
        CMD:  if (rise_q && bit_cnt == 4'd7)  nxt = DATA;
        DATA: if (rise_q && bit_cnt == 4'd15) nxt = DONE;
        default: nxt = DONE;
      endcase
    end
  end

  logic shift_en, cmd_last, commit, rd_shift, miso_zero;

  always_comb begin
    shift_en  = rise_q & ~ss_s & ((st == CMD) | (st == DATA));
    cmd_last  = shift_en & (st == CMD)  & (bit_cnt == 4'd7);
    commit    = shift_en & (st == DATA) & (bit_cnt == 4'd15);
    rd_shift  = fall_q & ~ss_s & (st == DATA) & ~w_q;
    miso_zero = ss_s | (st != DATA) | w_q;
  end

  // ---------------- datapath ----------------
  logic [7:0] sh_q, rd_sh, rd_val;
  logic [6:0] addr_q, cmd_addr;
  logic [7:0] fcnt;

  // On the 8th rise the incoming byte is {sh_q[6:0], mosi_q}.
  assign cmd_addr = {sh_q[5:0], mosi_q};

`ifdef SPIM1_PORT_SLAVE_FCNT_EN
  logic [7:0] fcnt_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) fcnt_q <= 8'h00;
    else if (commit)    fcnt_q <= fcnt_q + 8'd1;   // wraps 0xFF -> 0x00
  end
  assign fcnt = fcnt_q;
`else
  assign fcnt = 8'h00;
`endif

  always_comb begin
    rd_val = 8'h00;
    case (cmd_addr)
      7'd0: rd_val = ports_led;
      7'd1: rd_val = ports_gpio;
      7'd2: rd_val = {6'b0, key_s};
      7'd3: rd_val = ID_VALUE;
      7'd4: rd_val = fcnt;
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt    <= 4'd0;
      sh_q       <= 8'h00;
      w_q        <= 1'b0;
      addr_q     <= 7'd0;
      rd_sh      <= 8'h00;
      spi_miso   <= 1'b0;
      ports_led  <= 8'h00;
      ports_gpio <= 8'h00;
    end else begin
      if (st == IDLE)    bit_cnt <= 4'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) sh_q <= {sh_q[6:0], mosi_q};

      // The register value, including the key state, is frozen here for the
      // whole data byte.
      if (cmd_last) begin
        w_q    <= sh_q[6];
        addr_q <= cmd_addr;
        rd_sh  <= rd_val;
      end else if (rd_shift) begin
        rd_sh  <= {rd_sh[6:0], 1'b0};
      end

      if (miso_zero)     spi_miso <= 1'b0;
      else if (rd_shift) spi_miso <= rd_sh[7];

      if (commit && w_q) begin
        case (addr_q)
          7'd0: ports_led  <= {sh_q[6:0], mosi_q};
          7'd1: ports_gpio <= {sh_q[6:0], mosi_q};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spim1_port_slave.md
# spim1_port_slave

SPI target (responder) in the FPGA fabric answering the HPS SPI master (spim1: CLK, MOSI, MISO, SS0). It exposes a small register file over 16-bit SPI frames. Writable registers drive the board LED and GPIO outputs; read-only registers return the push-button state and a block ID. The HPS can therefore control the fabric ports without an Avalon bridge.

## Interface
Parameters:
- ID_VALUE, 8'h5A: constant returned by register 3.
- SYNC_STAGES, 2: flip-flop depth of the SCLK/MOSI/SS_N/key synchronizers (minimum 2).

Ports:
- clk_clk in 1: fabric clock. All logic is in this single domain.
- reset_reset_n in 1: reset, asynchronous assert, active-low.
- spi_sclk in 1: SPI clock from the HPS, mode 0 (CPOL=0, CPHA=0).
- spi_mosi in 1: master-out data, MSB first.
- spi_ss_n in 1: active-low target select.
- spi_miso out 1: target-out data, MSB first.
- ports_key in 2: raw push buttons, asynchronous.
- ports_led out 8: LED register.
- ports_gpio out 8: GPIO register.

## Operation
- Frame format, 16 bits: bit15 = W (1 = write, 0 = read); bits14:8 = ADDR; bits7:0 = DATA (write) or don't-care (read).
- Register map:
  - 0: LED, RW.
  - 1: GPIO, RW.
  - 2: KEY, RO, {6'b0, synced key}.
  - 3: ID, RO, ID_VALUE.
  - 4: FCNT, RO (see Configuration).
  - Other addresses read 0x00. Writes to them are ignored.
- Writes to RO addresses are ignored.
- Edge detection: SCLK, MOSI and SS_N are synchronized, then SCLK edges are detected on clk_clk. A rising edge samples MOSI. A falling edge updates MISO.
- FSM states:
  - IDLE: SS_N high. MISO = 0. Bit counter = 0. SS_N low -> CMD.
  - CMD: shift in 8 command bits. On the 8th rising edge, latch W and ADDR. For a read, load the read shift register with the register value. -> DATA.
  - DATA: shift in 8 data bits. For a read, MISO presents read bit 7 after the 8th falling edge, then bits 6..0 on successive falling edges. On the 16th rising edge, commit a write to its register. -> DONE.
  - DONE: further SCLK edges are ignored. MISO = 0. SS_N high -> IDLE.
- Abort: SS_N high in any state returns the FSM to IDLE on the next cycle. A frame aborted before the 16th rising edge performs no write and has no side effect.
- MISO is 0 during the command byte and during the data byte of a write.
- Key values are sampled into the read shift register at the CMD->DATA transition. Later key changes do not affect the frame in flight.

## Timing
- Reset values: ports_led = 0x00, ports_gpio = 0x00, spi_miso = 0, FSM = IDLE, FCNT = 0.
- Required: SCLK frequency ≤ clk_clk/8; SS_N setup and hold to the first/last SCLK edge ≥ 4 clk_clk periods.
- Input latency: SYNC_STAGES + 1 cycles from pin to detected edge.
- A write is visible on ports_led/ports_gpio exactly 1 cycle after the detected 16th rising edge.
- MISO updates 1 cycle after the detected falling edge. Worst case from the SCLK pin falling to MISO valid is SYNC_STAGES + 2 clk_clk cycles, which is within half an SCLK period at the frequency limit.
- Reset asserted mid-frame: all state clears immediately. A frame started before reset release is ignored until SS_N goes high (FSM waits in DONE if SS_N is low at reset release).
- Back-to-back frames require SS_N high for ≥ 4 clk_clk cycles.

## Configuration
- SPIM1_PORT_SLAVE_FCNT_EN defined:
  - Register 4 is an 8-bit count of completed 16-bit frames, reads and writes both counted.
  - Increments 1 cycle after the 16th rising edge and wraps 0xFF -> 0x00.
  - A read of register 4 returns the value before its own increment.
- Not defined: register 4 reads 0x00 and no counter logic is generated.

## Test plan
- Write frame 0x803C -> ports_led = 0x3C 1 cycle after the 16th edge. ports_gpio stays 0x00. MISO = 0 throughout.
- Read frame 0x0300 -> MISO returns 0x5A in the data byte. No output changes.
- ports_key = 2'b10, read frame 0x0200 -> MISO returns 0x02. Toggling the key during the data byte does not change the returned byte.
- Write 0x81AA, but raise SS_N after 10 bits -> ports_gpio stays 0x00. The next full write 0x8155 gives 0x55.
- With FCNT_EN: 3 complete frames plus 1 aborted frame, then read 0x0400 -> returns 0x03. Without FCNT_EN -> returns 0x00.
- Assert reset_reset_n low during bit 12 of write 0x80FF -> ports_led = 0x00 immediately. After release with SS_N still low, no write occurs. The next frame after an SS_N high period works normally.
